lcd_bus_arbiter: RTL and testbench
==================================

// Module: lcd_bus_arbiter
// PURPOSE
//  Owns the HD44780 4-bit LCD bus (RS, E, D7..D4) and shares it between two byte-level requesters.
//  Runs the power-up/init sequence itself, then arbitrates round-robin and serialises each byte as two nibbles.
//  Enforces E pulse width and per-command execution delays, so requesters never handle LCD timing.
//  Sits between the badge text sequencers/status logic and the LCD pins.
// PARAMETERS
//  CLK_DIV     4      clocks E is held high, then held low, per nibble
//  CMD_WAIT    50     idle clocks after a normal byte
//  LONG_WAIT   2000   idle clocks after RS=0 bytes 0x01/0x02/0x03 and after init nibbles 1-3
//  PWRUP_WAIT  20000  clocks from reset release before the first init nibble
// PORTS
//  CLK        in   1  clock
//  RST_N      in   1  asynchronous reset, active low
//  REQ0       in   1  requester 0 wants a byte sent; hold until GNT0
//  RS0        in   1  requester 0 register select (0 = command, 1 = data)
//  DAT0       in   8  requester 0 byte
//  GNT0       out  1  one-cycle pulse: RS0/DAT0 latched
//  REQ1/RS1/DAT1/GNT1 -- same as requester 0
//  BUSY       out  1  high unless in IDLE
//  INIT_DONE  out  1  sticky high once the init sequence completes
//  RS         out  1  LCD register select
//  E          out  1  LCD enable strobe
//  D          out  4  LCD D7..D4 (D[3] = D7)
// BEHAVIOUR
//  Reset (async, RST_N=0): E=0, RS=0, D=0, GNT0=GNT1=0, BUSY=1, INIT_DONE=0.
//   - Round-robin pointer -> requester 0; state -> PWRUP.
//   - Mid-operation reset drops E in the same instant; no partial nibble completes.
//  FSM: PWRUP -> INIT -> IDLE -> HI -> LO -> WAIT -> IDLE.
//  PWRUP: count PWRUP_WAIT clocks.
//  INIT: each step is one nibble cycle followed by its wait; RS=0 throughout.
//   - Nibbles 3,3,3: each followed by LONG_WAIT.
//   - Nibble 2: followed by CMD_WAIT.
//   - Then bytes 0x28, 0x0C, 0x01, 0x06, each followed by its byte wait. 0x01 takes LONG_WAIT.
//   - INIT_DONE rises on the cycle INIT hands over to IDLE.
//  Nibble cycle = 1 setup clock (RS/D driven, E=0) + CLK_DIV clocks E=1 + CLK_DIV clocks E=0.
//   - RS and D are stable for the whole nibble cycle.
//  IDLE arbitration, registered:
//   - One REQ high: grant it.
//   - Both high: grant the requester not granted last, then flip the pointer.
//   - Same clock: GNTx pulses, {RS,DAT} latched, next state HI. BUSY rises the following clock.
//   - No grant while INIT_DONE=0. REQ dropped before GNT is a legal withdrawal.
//  HI sends DAT[7:4]; LO sends DAT[3:0].
//  WAIT length: LONG_WAIT if RS=0 and DAT[7:2]==0, otherwise CMD_WAIT.
//   - IDLE can grant on the first clock after WAIT ends.
//  Byte period, GNT to next possible GNT = 2*(1+2*CLK_DIV) + wait + 1.
//  Counters are sized $clog2(max parameter + 1); no wrap is reachable.
//  Simultaneous REQ rise with INIT_DONE rise: arbitration starts the next clock.
// STRUCTURE
//  Package lcd_pkg:
//   - State enum.
//   - HD44780 constants: FUNC_4BIT_2L=0x28, DISP_ON=0x0C, CLEAR=0x01, ENTRY_INC=0x06.
//   - is_long_cmd() function.
//  Sub-module lcd_nibble_tx:
//   - In: START, RS_IN, NIB.
//   - Out: RS, E, D, DONE.
//   - Owns the setup/E-high/E-low timing.
//  Top keeps the FSM, init ROM index, wait counter and arbiter.
// TESTING (CLK_DIV=2, CMD_WAIT=5, LONG_WAIT=20, PWRUP_WAIT=30)
//  Reset release -> first E rise at clock 31 with D=3.
//   - D sequence: 3,3,3,2,2,8,0,C,0,1,0,6.
//   - INIT_DONE rises; no GNT before it.
//  After init, REQ0 with RS0=1, DAT0=0x48 ->
//   - GNT0 pulse.
//   - Nibbles 4 then 8 with RS=1; each E high exactly 2 clocks.
//   - BUSY low 16 clocks after GNT0.
//  REQ0 and REQ1 held high together ->
//   - Grants alternate 0,1,0,1.
//   - GNT spacing is 16 clocks (CMD_WAIT).
//  REQ1 with RS1=0, DAT1=0x01 -> WAIT lasts 20 clocks. DAT1=0x80 -> 5 clocks.
//  RST_N low while E=1 mid-byte ->
//   - E=0 immediately, BUSY=1, INIT_DONE=0.
//   - Full init reruns after release.
//  REQ0 pulsed 1 clock while BUSY, then dropped -> no GNT0, no bus activity.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and command classification for the LCD bus arbiter.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP, ST_INIT, ST_IDLE, ST_HI, ST_LO, ST_WAIT
   } arb_state_e;

   typedef enum logic [1:0] {
      TX_IDLE, TX_SETUP, TX_HIGH, TX_LOW
   } tx_state_e;

   localparam logic [7:0] FUNC_4BIT_2L = 8'h28;
   localparam logic [7:0] DISP_ON      = 8'h0C;
   localparam logic [7:0] CLEAR        = 8'h01;
   localparam logic [7:0] ENTRY_INC    = 8'h06;

   // Clear / return-home class commands need the long execution delay.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
      return !rs && (dat[7:2] == 6'd0);
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one nibble on the LCD bus: a setup clock, CLK_DIV clocks E high, CLK_DIV clocks E low.
module lcd_nibble_tx import lcd_pkg::*; #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rs_in,
   input  logic [3:0] nib,
   output logic       rs,
   output logic       e,
   output logic [3:0] d,
   output logic       done
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   tx_state_e     st, st_n;
   logic [DW-1:0] cnt, cnt_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st  <= TX_IDLE;
         cnt <= '0;
         rs  <= 1'b0;
         d   <= 4'h0;
      end else begin
         st  <= st_n;
         cnt <= cnt_n;
         if (start && (st == TX_IDLE || done)) begin
            rs <= rs_in;
            d  <= nib;
         end
      end
   end

   // A start during the last E-low clock chains the next nibble with no gap.
   always_comb begin
      st_n  = st;
      cnt_n = cnt;
      case (st)
         TX_IDLE:  if (start) st_n = TX_SETUP;
         TX_SETUP: begin
            st_n  = TX_HIGH;
            cnt_n = '0;
         end
         TX_HIGH:  if (cnt == LAST) begin
            st_n  = TX_LOW;
            cnt_n = '0;
         end else cnt_n = cnt + 1'b1;
         TX_LOW:   if (cnt == LAST) st_n = start ? TX_SETUP : TX_IDLE;
                   else cnt_n = cnt + 1'b1;
         default:  st_n = TX_IDLE;
      endcase
   end

   assign e    = (st == TX_HIGH);
   assign done = (st == TX_LOW) && (cnt == LAST);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// HD44780 4-bit bus owner: power-up init, round-robin arbitration of two byte requesters, timing.
module lcd_bus_arbiter import lcd_pkg::*; #(
   parameter int CLK_DIV    = 4,
   parameter int CMD_WAIT   = 50,
   parameter int LONG_WAIT  = 2000,
   parameter int PWRUP_WAIT = 20000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       rs0,
   input  logic [7:0] dat0,
   output logic       gnt0,
   input  logic       req1,
   input  logic       rs1,
   input  logic [7:0] dat1,
   output logic       gnt1,
   output logic       busy,
   output logic       init_done,
   output logic       rs,
   output logic       e,
   output logic [3:0] d
);

   localparam int MAXV = (PWRUP_WAIT > LONG_WAIT) ?
                         ((PWRUP_WAIT > CMD_WAIT) ? PWRUP_WAIT : CMD_WAIT) :
                         ((LONG_WAIT > CMD_WAIT) ? LONG_WAIT : CMD_WAIT);
   localparam int CW = $clog2(MAXV + 1);
   localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_WAIT - 1);
   localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_WAIT - 1);
   localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT - 1);

   arb_state_e    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    idx, idx_n, idx_inc;
   logic          waiting, waiting_n, ptr, ptr_n, done_n, sel;
   logic          lat_rs, lat_rs_n;
   logic [7:0]    lat_dat, lat_dat_n;
   logic          tx_start, tx_rs, tx_done;
   logic [3:0]    tx_nib;
   logic [CW-1:0] byte_last;

   // Init ROM: nibbles 0-3 are the raw 3,3,3,2 wake-up; 4-11 are four full command bytes.
   function automatic logic [7:0] init_byte(input logic [1:0] k);
      case (k)
         2'd0:    return FUNC_4BIT_2L;
         2'd1:    return DISP_ON;
         2'd2:    return CLEAR;
         default: return ENTRY_INC;
      endcase
   endfunction

   function automatic logic [1:0] byte_of(input logic [3:0] i);
      return 2'(i[3:1] - 3'd2);
   endfunction

   function automatic logic [3:0] init_nib(input logic [3:0] i);
      logic [7:0] b;
      b = init_byte(byte_of(i));
      if (i < 4'd3) return 4'h3;
      if (i == 4'd3) return 4'h2;
      return i[0] ? b[3:0] : b[7:4];
   endfunction

   function automatic logic [CW-1:0] init_last(input logic [3:0] i);
      if (i < 4'd3) return LONG_LAST;
      if (i == 4'd3) return CMD_LAST;
      return is_long_cmd(1'b0, init_byte(byte_of(i))) ? LONG_LAST : CMD_LAST;
   endfunction

   assign idx_inc   = idx + 4'd1;
   assign byte_last = is_long_cmd(lat_rs, lat_dat) ? LONG_LAST : CMD_LAST;
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_PWRUP;
         cnt       <= '0;
         idx       <= 4'd0;
         waiting   <= 1'b0;
         ptr       <= 1'b0;
         lat_rs    <= 1'b0;
         lat_dat   <= 8'h00;
         init_done <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         waiting   <= waiting_n;
         ptr       <= ptr_n;
         lat_rs    <= lat_rs_n;
         lat_dat   <= lat_dat_n;
         init_done <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      waiting_n = waiting;
      ptr_n     = ptr;
      lat_rs_n  = lat_rs;
      lat_dat_n = lat_dat;
      done_n    = init_done;
      tx_start  = 1'b0;
      tx_rs     = 1'b0;
      tx_nib    = 4'h0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      sel       = (req0 && req1) ? ptr : req1;
      case (state)
         ST_PWRUP: if (cnt == PWRUP_LAST) begin
            state_n   = ST_INIT;
            idx_n     = 4'd0;
            waiting_n = 1'b0;
            tx_start  = 1'b1;
            tx_nib    = init_nib(4'd0);
         end else cnt_n = cnt + 1'b1;
         ST_INIT: if (!waiting) begin
            // First nibble of an init byte chains straight into the second.
            if (tx_done) begin
               if (idx < 4'd4 || idx[0]) begin
                  waiting_n = 1'b1;
                  cnt_n     = '0;
               end else begin
                  idx_n    = idx_inc;
                  tx_start = 1'b1;
                  tx_nib   = init_nib(idx_inc);
               end
            end
         end else if (cnt == init_last(idx)) begin
            if (idx == 4'd11) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else begin
               idx_n     = idx_inc;
               waiting_n = 1'b0;
               tx_start  = 1'b1;
               tx_nib    = init_nib(idx_inc);
            end
         end else cnt_n = cnt + 1'b1;
         ST_IDLE: if (init_done && (req0 || req1)) begin
            gnt0      = !sel;
            gnt1      = sel;
            ptr_n     = !sel;
            lat_rs_n  = sel ? rs1 : rs0;
            lat_dat_n = sel ? dat1 : dat0;
            tx_start  = 1'b1;
            tx_rs     = lat_rs_n;
            tx_nib    = lat_dat_n[7:4];
            state_n   = ST_HI;
         end
         ST_HI: if (tx_done) begin
            tx_start = 1'b1;
            tx_rs    = lat_rs;
            tx_nib   = lat_dat[3:0];
            state_n  = ST_LO;
         end
         ST_LO: if (tx_done) begin
            state_n = ST_WAIT;
            cnt_n   = '0;
         end
         ST_WAIT: if (cnt == byte_last) state_n = ST_IDLE;
                  else cnt_n = cnt + 1'b1;
         default: state_n = ST_PWRUP;
      endcase
   end

   lcd_nibble_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .start (tx_start),
      .rs_in (tx_rs),
      .nib   (tx_nib),
      .rs    (rs),
      .e     (e),
      .d     (d),
      .done  (tx_done)
   );

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: scoreboard queues of expected nibbles and grants.
module tb_lcd_bus_arbiter;

   localparam int CLK_DIV = 2;

   logic       clk, rst_n;
   logic       req0, rs0, gnt0, req1, rs1, gnt1;
   logic [7:0] dat0, dat1;
   logic       busy, init_done, rs, e;
   logic [3:0] d;

   int vectors = 0, miscompares = 0;
   int cyc = 0, hcnt = 0, gnt_seen = 0, gnt_pushed = 0;
   logic prev_e = 1'b0;
   logic [4:0] nib_q[$];
   logic       gnt_q[$];

   localparam logic [3:0] INIT_D [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                          4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

   lcd_bus_arbiter #(.CLK_DIV(CLK_DIV), .CMD_WAIT(5), .LONG_WAIT(20), .PWRUP_WAIT(30)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .rs0(rs0), .dat0(dat0), .gnt0(gnt0),
      .req1(req1), .rs1(rs1), .dat1(dat1), .gnt1(gnt1),
      .busy(busy), .init_done(init_done), .rs(rs), .e(e), .d(d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor: pops expected nibbles on E rise, expected grants on GNT pulses.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         hcnt   = 0;
         prev_e = 1'b0;
      end else begin
         if (e && !prev_e) begin
            chk("nibble_expected", 32'(nib_q.size() > 0), 1);
            if (nib_q.size() > 0) chk("nibble", 32'({rs, d}), 32'(nib_q.pop_front()));
            hcnt = 1;
         end else if (e) hcnt++;
         else if (prev_e) chk("e_width", hcnt, CLK_DIV);
         if (gnt0 || gnt1) begin
            gnt_seen++;
            chk("gnt_after_init", 32'(init_done), 1);
            chk("gnt_expected", 32'(gnt_q.size() > 0), 1);
            if (gnt_q.size() > 0) chk("gnt_id", 32'({gnt1, gnt0}), gnt_q.pop_front() ? 2 : 1);
         end
         prev_e = e;
      end
   end

   task automatic wait_gnt();
      int n = 0;
      while (!(gnt0 || gnt1) && n < 600) begin
         @(negedge clk); #3;
         n++;
      end
      chk("gnt_seen", 32'(gnt0 || gnt1), 1);
   endtask

   task automatic wait_init();
      int n = 0;
      while (!init_done && n < 600) begin
         @(negedge clk); #3;
         n++;
      end
      chk("init_done_rise", 32'(init_done), 1);
   endtask

   task automatic push_init();
      for (int i = 0; i < 12; i++) nib_q.push_back({1'b0, INIT_D[i]});
   endtask

   task automatic expect_byte(input int ch, input logic r, input logic [7:0] v);
      nib_q.push_back({r, v[7:4]});
      nib_q.push_back({r, v[3:0]});
      gnt_q.push_back(ch[0]);
      gnt_pushed++;
   endtask

   task automatic busy_window(input int period);
      repeat (period - 2) @(negedge clk);
      #3 chk("busy_hold", 32'(busy), 1);
      @(negedge clk); #3;
      chk("busy_release", 32'(busy), 0);
   endtask

   task automatic run_byte(input int ch, input logic r, input logic [7:0] v, input int period);
      expect_byte(ch, r, v);
      @(negedge clk);
      if (ch == 0) begin req0 = 1'b1; rs0 = r; dat0 = v; end
      else         begin req1 = 1'b1; rs1 = r; dat1 = v; end
      #3 wait_gnt();
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      busy_window(period);
   endtask

   initial begin
      int last, n;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0; dat0 = 8'h00; dat1 = 8'h00;
      @(negedge clk); #3;
      chk("rst_e", 32'(e), 0);
      chk("rst_rs", 32'(rs), 0);
      chk("rst_d", 32'(d), 0);
      chk("rst_gnt", 32'({gnt1, gnt0}), 0);
      chk("rst_busy", 32'(busy), 1);
      chk("rst_init_done", 32'(init_done), 0);

      // Init sequence with requester 0 already waiting; its grant must follow INIT_DONE.
      push_init();
      expect_byte(0, 1'b1, 8'h48);
      @(negedge clk);
      rst_n = 1'b1; req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h48;
      repeat (30) @(posedge clk);
      #3 chk("e_low_before_31", 32'(e), 0);
      @(posedge clk); #3;
      chk("e_rise_31", 32'(e), 1);
      chk("d_first_init", 32'(d), 3);
      wait_gnt();
      @(negedge clk);
      req0 = 1'b0;
      busy_window(16);
      chk("init_and_0x48_drained", nib_q.size(), 0);

      run_byte(1, 1'b0, 8'h01, 31);
      run_byte(1, 1'b0, 8'h80, 16);

      // Both requesters held: alternating grants at CMD_WAIT byte period.
      for (int k = 0; k < 4; k++) expect_byte(k % 2, 1'b1, k[0] ? 8'h42 : 8'h41);
      @(negedge clk);
      req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h41;
      req1 = 1'b1; rs1 = 1'b1; dat1 = 8'h42;
      #3 last = 0;
      for (int k = 0; k < 4; k++) begin
         wait_gnt();
         if (k > 0) chk("gnt_spacing", cyc - last, 16);
         last = cyc;
         @(negedge clk);
         if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
         #3;
      end
      busy_window(16);
      chk("dual_drained", nib_q.size(), 0);

      // Withdrawal: a one-clock REQ0 while busy must not be granted.
      expect_byte(1, 1'b1, 8'h55);
      @(negedge clk);
      req1 = 1'b1; rs1 = 1'b1; dat1 = 8'h55;
      #3 wait_gnt();
      @(negedge clk);
      req1 = 1'b0; req0 = 1'b1; rs0 = 1'b0; dat0 = 8'h01;
      @(negedge clk);
      req0 = 1'b0;
      repeat (40) @(negedge clk);
      #3 chk("withdraw_idle", 32'(busy), 0);
      chk("withdraw_gnt_total", gnt_seen, gnt_pushed);
      chk("withdraw_drained", nib_q.size(), 0);

      // Reset while E is high: only the first nibble ever strobes.
      nib_q.push_back({1'b1, 4'h3});
      gnt_q.push_back(1'b0);
      gnt_pushed++;
      @(negedge clk);
      req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h3C;
      #3 wait_gnt();
      @(negedge clk);
      req0 = 1'b0;
      #3 n = 0;
      while (!e && n < 20) begin
         @(negedge clk); #3;
         n++;
      end
      chk("e_high_mid_byte", 32'(e), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_e", 32'(e), 0);
      chk("midrst_busy", 32'(busy), 1);
      chk("midrst_init_done", 32'(init_done), 0);
      chk("midrst_d", 32'(d), 0);
      push_init();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #3 wait_init();
      repeat (5) @(negedge clk);
      #3 chk("reinit_drained", nib_q.size(), 0);
      chk("gnt_q_drained", gnt_q.size(), 0);
      chk("gnt_total", gnt_seen, gnt_pushed);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
